// File: rtl/avaliador_batida_if.sv
// avaliador_batida_if: game-side and metronome-side signals of the rhythm judge
interface avaliador_batida_if #(
  parameter int W = 5
);
  logic         iniciar;
  logic         tecla;
  logic         metro;
  logic         meio_metro;
  logic         zeraMetro;
  logic         contaMetro;
  logic         acerto;
  logic         erro;
  logic [W-1:0] acertos;
  logic [W-1:0] batidas;
  logic         fim;
  logic [2:0]   estado;
  modport master (
    output iniciar, tecla, metro, meio_metro,
    input  zeraMetro, contaMetro, acerto, erro, acertos, batidas, fim, estado
  );
  modport slave (
    input  iniciar, tecla, metro, meio_metro,
    output zeraMetro, contaMetro, acerto, erro, acertos, batidas, fim, estado
  );
endinterface

// File: rtl/avaliador_batida.sv
// avaliador_batida: judges key presses against metronome beats and counts hits per round
module avaliador_batida #(
  parameter int NUM_BATIDAS = 16,
  parameter int TOLERANCIA  = 8
) (
  input logic clock,
  input logic reset,
  avaliador_batida_if.slave bus
);
  localparam int W  = $clog2(NUM_BATIDAS + 1);
  localparam int TW = TOLERANCIA > 1 ? $clog2(TOLERANCIA) : 1;
  typedef enum logic [2:0] {
    S_OCIOSO   = 3'd0,
    S_PREPARA  = 3'd1,
    S_PRIMEIRA = 3'd2,
    S_JANELA   = 3'd3,
    S_TOL      = 3'd4,
    S_FIM      = 3'd5
  } state_t;
  state_t        st;
  logic          tecla_d;
  logic          marcado;
  logic [TW-1:0] tol;
  logic [W-1:0]  acertos;
  logic [W-1:0]  batidas;
  logic          acerto;
  logic          erro;
  logic          press;
  logic          hit;
  logic          fecha;
  logic [W-1:0]  batidas_n;
  // press edge, first hit of the beat, and the last grace cycle after metro
  always_comb begin
    press     = bus.tecla & ~tecla_d;
    hit       = press & ~marcado;
    fecha     = tol == TW'(TOLERANCIA - 1);
    batidas_n = batidas + 1'b1;
  end
  // round FSM; a press on the closing grace cycle still counts as a hit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st      <= S_OCIOSO;
      tecla_d <= 1'b0;
      marcado <= 1'b0;
      tol     <= '0;
      acertos <= '0;
      batidas <= '0;
      acerto  <= 1'b0;
      erro    <= 1'b0;
    end else begin
      tecla_d <= bus.tecla;
      acerto  <= 1'b0;
      erro    <= 1'b0;
      case (st)
        S_OCIOSO, S_FIM: if (bus.iniciar) st <= S_PREPARA;
        S_PREPARA: begin
          acertos <= '0;
          batidas <= '0;
          marcado <= 1'b0;
          st      <= S_PRIMEIRA;
        end
        S_PRIMEIRA: begin
          if (bus.meio_metro) begin
            st      <= S_JANELA;
            marcado <= press;
            acerto  <= press;
            acertos <= acertos + W'(press);
          end else begin
            erro <= press;
          end
        end
        S_JANELA: begin
          if (hit) begin
            acerto  <= 1'b1;
            marcado <= 1'b1;
            acertos <= acertos + 1'b1;
          end
          if (bus.metro) begin
            st  <= S_TOL;
            tol <= '0;
          end
        end
        S_TOL: begin
          tol <= tol + 1'b1;
          if (hit) begin
            acerto  <= 1'b1;
            marcado <= 1'b1;
            acertos <= acertos + 1'b1;
          end
          if (fecha) begin
            batidas <= batidas_n;
            erro    <= ~marcado & ~press;
            st      <= batidas_n == W'(NUM_BATIDAS) ? S_FIM : S_PRIMEIRA;
          end
        end
        default: st <= S_OCIOSO;
      endcase
    end
  end
  assign bus.zeraMetro  = st == S_OCIOSO || st == S_PREPARA;
  assign bus.contaMetro = st == S_PRIMEIRA || st == S_JANELA || st == S_TOL;
  assign bus.fim        = st == S_FIM;
  assign bus.estado     = st;
  assign bus.acerto     = acerto;
  assign bus.erro       = erro;
  assign bus.acertos    = acertos;
  assign bus.batidas    = batidas;
endmodule

// File: tb/tb_avaliador_batida.sv
// tb_avaliador_batida: directed rounds against a beat-level model of the rhythm judge
module tb_avaliador_batida;
  localparam int NB  = 4;
  localparam int TOL = 4;
  localparam int W   = $clog2(NB + 1);
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int n_ac = 0;
  int n_er = 0;
  int cnt = 0;
  avaliador_batida_if #(.W(W)) bus();
  avaliador_batida #(.NUM_BATIDAS(NB), .TOLERANCIA(TOL)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  // bench metronome: 20-cycle beat, half-beat pulse 10 cycles before metro
  always @(posedge clock)
    cnt <= bus.zeraMetro ? 0 : bus.contaMetro ? (cnt == 19 ? 0 : cnt + 1) : cnt;
  assign bus.metro      = bus.contaMetro && cnt == 19;
  assign bus.meio_metro = bus.contaMetro && cnt == 9;
  // beat-level model: round phase flags, grace countdown, hit/beat tallies
  bit prep, on, done, win, hit, prev_key, e_ac, e_er, p;
  int grace, hits, beats;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      prep = 0; on = 0; done = 0; win = 0; hit = 0; prev_key = 0;
      e_ac = 0; e_er = 0; grace = 0; hits = 0; beats = 0;
    end else begin
      p = bus.tecla && !prev_key;
      prev_key = bus.tecla;
      e_ac = 0;
      e_er = 0;
      if (prep) begin
        prep = 0; on = 1; hits = 0; beats = 0; hit = 0; win = 0; grace = 0;
      end else if (on) begin
        if (grace > 0) begin
          if (p && !hit) begin e_ac = 1; hit = 1; hits++; end
          grace--;
          if (grace == 0) begin
            beats++;
            e_er = !hit;
            if (beats == NB) begin on = 0; done = 1; end
          end
        end else if (win) begin
          if (p && !hit) begin e_ac = 1; hit = 1; hits++; end
          if (bus.metro) begin win = 0; grace = TOL; end
        end else if (bus.meio_metro) begin
          win = 1; hit = p; e_ac = p; hits += int'(p);
        end else begin
          e_er = p;
        end
      end else if (bus.iniciar) begin
        prep = 1; done = 0;
      end
    end
  end
  // every-cycle comparison of all outputs against the model
  logic [2*W+7:0] got, exp;
  int m_est;
  always @(negedge clock) begin
    m_est = prep ? 1 : done ? 5 : on ? (grace > 0 ? 4 : win ? 3 : 2) : 0;
    got = {bus.zeraMetro, bus.contaMetro, bus.acerto, bus.erro, bus.acertos, bus.batidas, bus.fim, bus.estado};
    exp = {!on && !done, on, e_ac, e_er, hits[W-1:0], beats[W-1:0], done, m_est[2:0]};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, got, exp);
    end
    if (bus.acerto === 1'b1) n_ac++;
    if (bus.erro === 1'b1) n_er++;
  end
  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, g, e);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic press();
    bus.tecla = 1'b1;
    @(negedge clock);
    bus.tecla = 1'b0;
  endtask
  task automatic wait_ev(input bit m);
    for (int i = 0; i < 100 && !(m ? bus.metro : bus.meio_metro); i++) @(negedge clock);
    chk(m ? "wait_metro" : "wait_meio", m ? bus.metro : bus.meio_metro, 1);
  endtask
  task automatic wait_fim();
    for (int i = 0; i < 300 && bus.fim !== 1'b1; i++) @(negedge clock);
    chk("wait_fim", bus.fim, 1);
    step(1);
  endtask
  task automatic start();
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    chk("prepara_estado", bus.estado, 1);
    chk("prepara_zera", bus.zeraMetro, 1);
    @(negedge clock);
    chk("start_conta", bus.contaMetro, 1);
    chk("start_estado", bus.estado, 2);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int a0, e0;
    bus.iniciar = 1'b0;
    bus.tecla   = 1'b0;
    step(3);
    chk("rst_zera", bus.zeraMetro, 1);
    chk("rst_conta", bus.contaMetro, 0);
    chk("rst_acertos", bus.acertos, 0);
    chk("rst_batidas", bus.batidas, 0);
    chk("rst_fim", bus.fim, 0);
    chk("rst_pulses", {bus.acerto, bus.erro}, 0);
    #2 reset = 1'b0;
    step(11);
    chk("idle_zera", bus.zeraMetro, 1);
    chk("idle_conta", bus.contaMetro, 0);
    chk("idle_estado", bus.estado, 0);
    // round 1: press 3 cycles after each half-beat
    a0 = n_ac; e0 = n_er;
    start();
    repeat (NB) begin wait_ev(0); step(3); press(); end
    wait_fim();
    chk("r1_acerto_pulses", n_ac - a0, 4);
    chk("r1_erro_pulses", n_er - e0, 0);
    chk("r1_acertos", bus.acertos, 4);
    chk("r1_batidas", bus.batidas, 4);
    chk("r1_conta", bus.contaMetro, 0);
    // round 2: no presses at all
    a0 = n_ac; e0 = n_er;
    start();
    wait_fim();
    chk("r2_acerto_pulses", n_ac - a0, 0);
    chk("r2_erro_pulses", n_er - e0, 4);
    chk("r2_acertos", bus.acertos, 0);
    chk("r2_batidas", bus.batidas, 4);
    // round 3: grace hit, closing-cycle hit, double press, stray press then miss
    a0 = n_ac; e0 = n_er;
    start();
    wait_ev(1); step(3); press();
    wait_ev(1); step(4); press();
    wait_ev(0); step(2); press(); step(1); press();
    wait_ev(1); step(6); press();
    wait_fim();
    chk("r3_acerto_pulses", n_ac - a0, 3);
    chk("r3_erro_pulses", n_er - e0, 2);
    chk("r3_acertos", bus.acertos, 3);
    chk("r3_batidas", bus.batidas, 4);
    // round 4: reset during the window of beat 2
    start();
    wait_ev(0); step(3); press();
    wait_ev(0); step(3);
    chk("r4_pre_acertos", bus.acertos, 1);
    chk("r4_pre_batidas", bus.batidas, 1);
    chk("r4_pre_estado", bus.estado, 3);
    #2 reset = 1'b1;
    #1;
    chk("r4_rst_zera", bus.zeraMetro, 1);
    chk("r4_rst_conta", bus.contaMetro, 0);
    chk("r4_rst_acertos", bus.acertos, 0);
    chk("r4_rst_batidas", bus.batidas, 0);
    chk("r4_rst_estado", bus.estado, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    start();
    chk("r5_batidas", bus.batidas, 0);
    wait_ev(0); step(3); press();
    wait_ev(1); step(6);
    chk("r5_acertos", bus.acertos, 1);
    chk("r5_batidas_after", bus.batidas, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
